// File: rtl/face_select_ctrl.sv
// Maps a sampled sound level to a face code (Happy/Neutral/Angry) with hysteresis
// and a frame-count hold; a new face is committed only on a frame_end edge.
module face_select_ctrl #(
  parameter int LEVEL_W     = 16,
  parameter int T_LO        = 1000,
  parameter int T_HI        = 3000,
  parameter int HYST        = 100,
  parameter int HOLD_FRAMES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] level,
  input  logic               level_valid,
  input  logic               frame_end,
  output logic [1:0]         face_select,
  output logic               face_changed,
  output logic               pending
);

  localparam int CNT_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [1:0] FACE_HAPPY   = 2'd0;
  localparam logic [1:0] FACE_NEUTRAL = 2'd1;
  localparam logic [1:0] FACE_ANGRY   = 2'd2;

  // Thresholds held one bit wider than the level so T_HI+HYST cannot wrap.
  localparam logic [LEVEL_W:0] HI_UP = (LEVEL_W+1)'(T_HI + HYST);
  localparam logic [LEVEL_W:0] HI_DN = (LEVEL_W+1)'(T_HI - HYST);
  localparam logic [LEVEL_W:0] LO_UP = (LEVEL_W+1)'(T_LO + HYST);
  localparam logic [LEVEL_W:0] LO_DN = (LEVEL_W+1)'(T_LO - HYST);

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } state_e;

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q;
  logic [1:0]         face_q, face_d;
  logic [1:0]         cand_q, cand_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic               changed_q, changed_d;
  logic [1:0]         target;

  function automatic logic [1:0] target_of(input logic [LEVEL_W:0] lvl,
                                           input logic [1:0]       cur);
    logic [1:0] t;
    t = cur;
    case (cur)
      FACE_HAPPY: begin
        if (lvl >= HI_UP)      t = FACE_ANGRY;
        else if (lvl >= LO_UP) t = FACE_NEUTRAL;
        else                   t = FACE_HAPPY;
      end
      FACE_ANGRY: begin
        if (lvl < LO_DN)      t = FACE_HAPPY;
        else if (lvl < HI_DN) t = FACE_NEUTRAL;
        else                  t = FACE_ANGRY;
      end
      default: begin
        if (lvl >= HI_UP)     t = FACE_ANGRY;
        else if (lvl < LO_DN) t = FACE_HAPPY;
        else                  t = FACE_NEUTRAL;
      end
    endcase
    return t;
  endfunction

  assign target = target_of({1'b0, level_q}, face_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      level_q   <= '0;
      face_q    <= FACE_NEUTRAL;
      cand_q    <= FACE_NEUTRAL;
      hold_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      face_q    <= face_d;
      cand_q    <= cand_d;
      hold_q    <= hold_d;
      changed_q <= changed_d;
      if (level_valid) level_q <= level;
    end
  end

  always_comb begin
    state_d   = state_q;
    face_d    = face_q;
    cand_d    = cand_q;
    hold_d    = hold_q;
    changed_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cand_d = face_q;
        hold_d = '0;
        if (target != face_q) begin
          state_d = ST_PEND;
          cand_d  = target;
        end
      end
      default: begin
        if (target == face_q) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else if (target != cand_q) begin
          // A different face took over: restart the hold, ignoring any frame_end now.
          cand_d = target;
          hold_d = '0;
        end else if (frame_end) begin
          if (hold_q == CNT_W'(HOLD_FRAMES - 1)) begin
            face_d    = cand_q;
            hold_d    = '0;
            state_d   = ST_IDLE;
            changed_d = 1'b1;
          end else begin
            hold_d = hold_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  assign face_select  = face_q;
  assign face_changed = changed_q;
  assign pending      = (state_q == ST_PEND);

endmodule

// File: tb/tb_face_select_ctrl.sv
// Bench for face_select_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_face_select_ctrl;

  localparam int LEVEL_W = 16;
  localparam int T_LO    = 1000;
  localparam int T_HI    = 3000;
  localparam int HYST    = 100;
  localparam int HOLD    = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [LEVEL_W-1:0] level = '0;
  logic               level_valid = 1'b0;
  logic               frame_end = 1'b0;
  logic [1:0]         face_select;
  logic               face_changed;
  logic               pending;

  int tests = 0;
  int fails = 0;

  // Model state: committed face, last sampled level, whether a change is pending,
  // the face being waited for and how many qualifying frame ends it has survived.
  int m_face = 1, m_lvl = 0, m_cand = 1, m_seen = 0;
  bit m_pend = 0, m_chg = 0;

  face_select_ctrl #(.LEVEL_W(LEVEL_W), .T_LO(T_LO), .T_HI(T_HI), .HYST(HYST),
                     .HOLD_FRAMES(HOLD)) dut (
    .clk(clk), .reset(reset), .level(level), .level_valid(level_valid),
    .frame_end(frame_end), .face_select(face_select), .face_changed(face_changed),
    .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic int want_face(int lvl, int face);
    if (face == 0) return (lvl >= T_HI + HYST) ? 2 : (lvl >= T_LO + HYST) ? 1 : 0;
    if (face == 2) return (lvl < T_LO - HYST) ? 0 : (lvl < T_HI - HYST) ? 1 : 2;
    return (lvl >= T_HI + HYST) ? 2 : (lvl < T_LO - HYST) ? 0 : 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int t;
    if (reset) begin
      m_face = 1; m_lvl = 0; m_cand = 1; m_seen = 0; m_pend = 0; m_chg = 0;
    end else begin
      t = want_face(m_lvl, m_face);
      m_chg = 0;
      if (!m_pend) begin
        if (t != m_face) begin m_pend = 1; m_cand = t; m_seen = 0; end
      end else if (t == m_face) begin
        m_pend = 0; m_seen = 0;
      end else if (t != m_cand) begin
        m_cand = t; m_seen = 0;
      end else if (frame_end) begin
        m_seen++;
        if (m_seen == HOLD) begin
          m_face = m_cand; m_pend = 0; m_seen = 0; m_chg = 1;
        end
      end
      if (level_valid) m_lvl = int'(level);
    end
  end

  always @(negedge clk) begin
    check("face_select", int'(face_select), m_face);
    check("face_changed", int'(face_changed), int'(m_chg));
    check("pending", int'(pending), int'(m_pend));
    check("hold_cnt", int'(dut.hold_q), m_seen);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_level(input int v);
    level = LEVEL_W'(v);
    level_valid = 1'b1;
    cyc();
    level_valid = 1'b0;
    cyc();
  endtask

  task automatic frame(input int gap);
    cyc(gap);
    frame_end = 1'b1;
    cyc();
    frame_end = 1'b0;
  endtask

  initial begin
    int ths[6];
    ths = '{900, 1000, 1100, 2900, 3000, 3100};

    // Reset behaviour and the first level of 0 going pending towards Happy.
    cyc(2);
    check("rst face", int'(face_select), 1);
    check("rst changed", int'(face_changed), 0);
    check("rst pending", int'(pending), 0);
    reset = 1'b0;
    cyc();
    check("post-rst pending", int'(pending), 1);
    check("post-rst hold", int'(dut.hold_q), 0);

    // Neutral -> Happy after three frame ends spaced 100 cycles.
    send_level(500);
    frame(99);
    check("t2 f1 face", int'(face_select), 1);
    frame(99);
    check("t2 f2 face", int'(face_select), 1);
    frame(99);
    check("t2 f3 face", int'(face_select), 0);
    check("t2 changed", int'(face_changed), 1);
    cyc();
    check("t2 changed drop", int'(face_changed), 0);
    check("t2 pending", int'(pending), 0);

    // Inside the hysteresis band nothing moves; a big jump goes straight to Angry.
    send_level(1050);
    repeat (10) frame(3);
    check("t3 hyst face", int'(face_select), 0);
    check("t3 hyst pending", int'(pending), 0);
    send_level(4000);
    repeat (3) frame(2);
    check("t3 angry", int'(face_select), 2);

    // Back to Neutral, then an aborted excursion towards Angry.
    send_level(2000);
    repeat (3) frame(2);
    check("t4 neutral", int'(face_select), 1);
    send_level(3200);
    repeat (2) frame(2);
    check("t4 hold", int'(dut.hold_q), 2);
    send_level(2000);
    check("t4 pending drop", int'(pending), 0);
    repeat (5) frame(2);
    check("t4 face", int'(face_select), 1);

    // New level coincident with the committing frame end: old level decides.
    send_level(3200);
    repeat (2) frame(2);
    level = 16'd500;
    level_valid = 1'b1;
    frame_end = 1'b1;
    cyc();
    level_valid = 1'b0;
    frame_end = 1'b0;
    check("t5 commit angry", int'(face_select), 2);
    check("t5 changed", int'(face_changed), 1);
    cyc();
    check("t5 pend happy", int'(pending), 1);
    repeat (2) frame(2);
    check("t5 still angry", int'(face_select), 2);
    frame(2);
    check("t5 happy", int'(face_select), 0);

    // Reset wins over a frame end that would otherwise commit.
    send_level(3200);
    repeat (2) frame(2);
    reset = 1'b1;
    frame_end = 1'b1;
    cyc();
    frame_end = 1'b0;
    check("t6 face", int'(face_select), 1);
    check("t6 hold", int'(dut.hold_q), 0);
    check("t6 changed", int'(face_changed), 0);
    check("t6 pending", int'(pending), 0);
    reset = 1'b0;

    // Randomized traffic clustered around the thresholds.
    for (int i = 0; i < 4000; i++) begin
      level_valid = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) level = LEVEL_W'($urandom);
      else level = LEVEL_W'(ths[$urandom_range(0, 5)] + $urandom_range(0, 4) - 2);
      frame_end = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 599) == 0);
      cyc();
    end
    reset = 1'b0;
    level_valid = 1'b0;
    frame_end = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/face_select_ctrl.md
Name: face_select_ctrl

Overview:
- Upstream control stage for the face pixel streamer.
- Converts a sampled sound-level word into the 2-bit face_select code: 0 Happy, 1 Neutral, 2 Angry.
- Applies threshold hysteresis and a frame-count hold time.
- Commits a new face only at a frame boundary, so the streamer never switches images mid-frame. No tearing.

Parameters:
LEVEL_W, 16, width of the unsigned level input
T_LO, 1000, Happy/Neutral boundary
T_HI, 3000, Neutral/Angry boundary; must satisfy T_HI > T_LO + 2*HYST
HYST, 100, hysteresis margin; must satisfy HYST <= T_LO
HOLD_FRAMES, 3, consecutive frame ends a new target must persist before commit; range 1..255

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
level  in  LEVEL_W  unsigned sound level sample
level_valid  in  1  one-cycle qualifier; level is sampled when high
frame_end  in  1  one-cycle pulse on the streamer's endofpacket & valid & ready handshake cycle
face_select  out  2  committed face code, drives the streamer's face_select
face_changed  out  1  one-cycle pulse in the cycle after face_select is updated
pending  out  1  high while the target differs from face_select

Behaviour:
- Reset values: face_select=1 (Neutral), face_changed=0, pending=0, level_q=0, candidate=1, hold_cnt=0. Reset dominates every other input, including frame_end.

Level capture:
- level_q <= level when level_valid.
- target is combinational from level_q and face_select, so level changes act on target one cycle after level_valid.

Target rules (compares in LEVEL_W+1 bits; no over/underflow):
- face_select=Happy: Angry if level_q >= T_HI+HYST; else Neutral if level_q >= T_LO+HYST; else Happy.
- face_select=Neutral: Angry if level_q >= T_HI+HYST; Happy if level_q < T_LO-HYST; else Neutral.
- face_select=Angry: Happy if level_q < T_LO-HYST; else Neutral if level_q < T_HI-HYST; else Angry.
- face_select is never driven to 3.

State machine (pending = state==PEND):
- IDLE: candidate <= face_select, hold_cnt <= 0.
  - If target != face_select: go to PEND, candidate <= target, hold_cnt <= 0. The transition cycle does not count a frame_end even if one is present.
- PEND, target == face_select: go to IDLE, hold_cnt <= 0.
- PEND, target != candidate (a different non-current face): candidate <= target, hold_cnt <= 0, stay in PEND. A frame_end in this cycle is not counted.
- PEND, target == candidate, frame_end:
  - If hold_cnt == HOLD_FRAMES-1: face_select <= candidate, hold_cnt <= 0, go to IDLE. face_changed=1 in the next cycle only.
  - Otherwise hold_cnt <= hold_cnt+1.
- hold_cnt width is clog2(HOLD_FRAMES+1) and never exceeds HOLD_FRAMES-1.

Timing and boundary conditions:
- face_select changes only on the clock edge of a frame_end cycle. The streamer's next pixel, index 0, therefore uses the new face.
- level_valid coincident with frame_end: that frame_end is evaluated with the old level_q.
- HOLD_FRAMES=1: commit occurs at the first frame_end seen while in PEND.
- No frame_end activity (e.g. sink stalled): no commit; the state persists indefinitely.

Test Plan:
1. Assert reset for 2 cycles, then level=0, no frame_end -> face_select=1, face_changed=0. After reset release: pending=1 (0 < T_LO-HYST=900), hold_cnt=0.
2. Deliver level=500, then 3 frame_end pulses 100 cycles apart -> face_select stays 1 after pulses 1 and 2, becomes 0 on pulse 3's edge; face_changed high exactly 1 cycle; pending=0.
3. From Happy, level=1050 (below T_LO+HYST=1100) and 10 frame_ends -> face_select stays 0, pending=0. Then level=4000 and 3 frame_ends -> face_select=2 directly.
4. From Neutral: level=3200 for 2 frame_ends (hold_cnt=2), then level=2000, then 5 frame_ends -> pending drops one cycle after the level update, face_select stays 1, face_changed never pulses.
5. From Neutral: level=3200 with pending and hold_cnt=2, then level_valid with level=500 coincident with the 3rd frame_end -> commit to Angry on that edge. The candidate then becomes Happy in PEND, requiring 3 further frame_ends.
6. Pending with hold_cnt=2, reset asserted in the same cycle as frame_end -> face_select=1, hold_cnt=0, face_changed=0, pending=0.
